// File: rtl/fmap_pingpong_ctrl.sv
// rtl/fmap_pingpong_ctrl.sv - ping-pong bank controller for the dual-port feature-map RAM
//
// The RAM is split into two banks, selected by the address MSB. The producer
// fills one bank through port A while the consumer reads the other through
// port B. Banks change hands by handshake.
//
// Ports:
//   clock, reset        system clock; asynchronous active-high reset
//   prod_wr_en/data     producer word strobe and word
//   prod_ready          the producer's current bank can accept a word
//   cons_rd_req/addr    consumer read request and in-bank address
//   cons_release        consumer is finished with the current bank
//   cons_valid          the consumer's current bank is full
//   overflow            sticky flag: a producer word was dropped
//   data_a, address_a_t, wren_a, rden_a   RAM port A (write only)
//   address_b_t, rden_b, data_b, wren_b   RAM port B (read only)
module fmap_pingpong_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int POOL_ADDR_WIDTH = 2,
    parameter int FRAME_WORDS     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       prod_wr_en,
    input  logic [DATA_WIDTH-1:0]      prod_data,
    output logic                       prod_ready,
    input  logic                       cons_rd_req,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_addr,
    input  logic                       cons_release,
    output logic                       cons_valid,
    output logic                       overflow,
    output logic [DATA_WIDTH-1:0]      data_a,
    output logic [POOL_ADDR_WIDTH:0]   address_a_t,
    output logic                       wren_a,
    output logic                       rden_a,
    output logic [POOL_ADDR_WIDTH:0]   address_b_t,
    output logic                       rden_b,
    output logic [DATA_WIDTH-1:0]      data_b,
    output logic                       wren_b
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam logic [POOL_ADDR_WIDTH-1:0] LAST_WORD = POOL_ADDR_WIDTH'(FRAME_WORDS - 1);

    bank_state_t                bank_state [2];
    logic                       wr_bank;
    logic                       rd_bank;
    logic [POOL_ADDR_WIDTH-1:0] wr_cnt;

    logic wr_accept;
    logic wr_last;
    logic rd_accept;
    logic rel_accept;

    assign prod_ready = (bank_state[wr_bank] != FULL);
    assign cons_valid = (bank_state[rd_bank] == FULL);

    assign wr_accept  = prod_wr_en & prod_ready;
    assign wr_last    = (wr_cnt == LAST_WORD);
    assign rd_accept  = cons_rd_req & cons_valid;
    assign rel_accept = cons_release & cons_valid;

    // The unused directions of each RAM port are tied off.
    assign rden_a = 1'b0;
    assign data_b = '0;
    assign wren_b = 1'b0;

    // A write and a release can never target the same bank on one edge: a
    // write needs its bank not FULL, a release needs its bank FULL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_cnt        <= '0;
            overflow      <= 1'b0;
            wren_a        <= 1'b0;
            data_a        <= '0;
            address_a_t   <= '0;
            rden_b        <= 1'b0;
            address_b_t   <= '0;
        end else begin
            wren_a <= wr_accept;
            rden_b <= rd_accept;

            if (wr_accept) begin
                data_a      <= prod_data;
                address_a_t <= {wr_bank, wr_cnt};
                if (wr_last) begin
                    bank_state[wr_bank] <= FULL;
                    wr_cnt              <= '0;
                    wr_bank             <= ~wr_bank;
                end else begin
                    bank_state[wr_bank] <= FILLING;
                    wr_cnt              <= wr_cnt + 1'b1;
                end
            end

            if (prod_wr_en && !prod_ready) begin
                overflow <= 1'b1;
            end

            // Address is taken from rd_bank before any toggle, so a read
            // issued in the release cycle still hits the bank being released.
            if (rd_accept) begin
                address_b_t <= {rd_bank, cons_addr};
            end

            if (rel_accept) begin
                bank_state[rd_bank] <= EMPTY;
                rd_bank             <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fmap_pingpong_ctrl.sv
// tb/tb_fmap_pingpong_ctrl.sv - scoreboard bench for fmap_pingpong_ctrl
module tb_fmap_pingpong_ctrl;

    localparam int DW = 8;
    localparam int PW = 2;
    localparam int FW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          prod_wr_en = 1'b0;
    logic [DW-1:0] prod_data = '0;
    logic          prod_ready;
    logic          cons_rd_req = 1'b0;
    logic [PW-1:0] cons_addr = '0;
    logic          cons_release = 1'b0;
    logic          cons_valid;
    logic          overflow;
    logic [DW-1:0] data_a;
    logic [PW:0]   address_a_t;
    logic          wren_a;
    logic          rden_a;
    logic [PW:0]   address_b_t;
    logic          rden_b;
    logic [DW-1:0] data_b;
    logic          wren_b;

    fmap_pingpong_ctrl #(
        .DATA_WIDTH(DW), .POOL_ADDR_WIDTH(PW), .FRAME_WORDS(FW)
    ) dut (
        .clock(clock), .reset(reset),
        .prod_wr_en(prod_wr_en), .prod_data(prod_data), .prod_ready(prod_ready),
        .cons_rd_req(cons_rd_req), .cons_addr(cons_addr), .cons_release(cons_release),
        .cons_valid(cons_valid), .overflow(overflow),
        .data_a(data_a), .address_a_t(address_a_t), .wren_a(wren_a), .rden_a(rden_a),
        .address_b_t(address_b_t), .rden_b(rden_b), .data_b(data_b), .wren_b(wren_b)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected port-A writes {addr, data} and port-B reads {addr}.
    logic [PW+DW:0] wq[$];
    logic [PW:0]    rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM strobe must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset) begin
            if (wren_a) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wren_a", {21'd0, address_a_t, data_a}, 32'hffff_ffff);
                end else begin
                    logic [PW+DW:0] e;
                    e = wq.pop_front();
                    chk("port_a_write", {21'd0, address_a_t, data_a}, {21'd0, e});
                end
            end
            if (rden_b) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rden_b", {29'd0, address_b_t}, 32'hffff_ffff);
                end else begin
                    logic [PW:0] r;
                    r = rq.pop_front();
                    chk("port_b_read", {29'd0, address_b_t}, {29'd0, r});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d, input bit acc, input logic b, input logic [PW-1:0] c);
        prod_wr_en = 1'b1;
        prod_data  = d;
        if (acc) wq.push_back({b, c, d});
        step();
        prod_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [PW-1:0] a, input bit acc, input logic b, input bit rel);
        cons_rd_req  = 1'b1;
        cons_addr    = a;
        cons_release = rel;
        if (acc) rq.push_back({b, a});
        step();
        cons_rd_req  = 1'b0;
        cons_release = 1'b0;
    endtask

    task automatic release_bank();
        cons_release = 1'b1;
        step();
        cons_release = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_prod_ready"}, {31'd0, prod_ready}, 32'd1);
        chk({tag, "_cons_valid"}, {31'd0, cons_valid}, 32'd0);
        chk({tag, "_overflow"},   {31'd0, overflow},   32'd0);
        chk({tag, "_ram_a"}, {20'd0, wren_a, address_a_t, data_a}, 32'd0);
        chk({tag, "_ram_b"}, {28'd0, rden_b, address_b_t}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        chk("tie_offs", {22'd0, rden_a, wren_b, data_b}, 32'd0);
        reset = 1'b0;
        step();

        // Fill bank 0 with 1..4.
        for (int i = 0; i < 4; i++) wr(DW'(i + 1), 1'b1, 1'b0, PW'(i));
        chk("bank0_full_valid", {31'd0, cons_valid}, 32'd1);
        chk("bank1_ready",      {31'd0, prod_ready}, 32'd1);

        // Fill bank 1 with 5..8, then a dropped 9th write.
        for (int i = 0; i < 4; i++) wr(DW'(i + 5), 1'b1, 1'b1, PW'(i));
        chk("both_full_not_ready", {31'd0, prod_ready}, 32'd0);
        wr(8'h99, 1'b0, 1'b0, '0);
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        step();
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Read bank 0 address 2, then read address 3 in the release cycle.
        rd(2'd2, 1'b1, 1'b0, 1'b0);
        chk("valid_hold_after_read", {31'd0, cons_valid}, 32'd1);
        rd(2'd3, 1'b1, 1'b0, 1'b1);
        chk("valid_after_release_bank1_full", {31'd0, cons_valid}, 32'd1);
        chk("ready_after_release",            {31'd0, prod_ready}, 32'd1);

        // Release bank 1; bank 0 empty so nothing to read.
        release_bank();
        chk("valid_after_release_none_full", {31'd0, cons_valid}, 32'd0);

        // Bank 0 gets 9..12, bank 1 gets 13..15, last write races a release.
        for (int i = 0; i < 4; i++) wr(DW'(i + 9), 1'b1, 1'b0, PW'(i));
        for (int i = 0; i < 3; i++) wr(DW'(i + 13), 1'b1, 1'b1, PW'(i));
        cons_release = 1'b1;
        wr(8'd16, 1'b1, 1'b1, 2'd3);
        cons_release = 1'b0;
        chk("same_edge_cons_valid", {31'd0, cons_valid}, 32'd1);
        chk("same_edge_prod_ready", {31'd0, prod_ready}, 32'd1);
        rd(2'd1, 1'b1, 1'b1, 1'b0);
        wr(8'd17, 1'b1, 1'b0, 2'd0);
        step();

        // Reset in the middle of a frame.
        wr(8'h21, 1'b1, 1'b0, 2'd1);
        step();
        reset = 1'b1;
        #2;
        chk_reset_outputs("midreset");
        step();
        reset = 1'b0;
        wr(8'h31, 1'b1, 1'b0, 2'd0);
        wr(8'h32, 1'b1, 1'b0, 2'd1);

        // Read and release with no full bank are ignored.
        rd(2'd2, 1'b0, 1'b0, 1'b1);
        chk("ignored_ops_valid", {31'd0, cons_valid}, 32'd0);
        step();
        chk("ignored_rden_b", {31'd0, rden_b}, 32'd0);
        wr(8'h33, 1'b1, 1'b0, 2'd2);
        wr(8'h34, 1'b1, 1'b0, 2'd3);
        chk("rd_bank_unchanged", {31'd0, cons_valid}, 32'd1);
        rd(2'd0, 1'b1, 1'b0, 1'b0);
        step();
        step();

        chk("write_queue_drained", wq.size(), 32'd0);
        chk("read_queue_drained",  rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
